// File: rtl/alu_cmd_issuer.sv
// Command initiator for the two-stage team ALU: issues tagged operand pulses,
// reserves a result slot per command and returns results in order over valid/ready.
module alu_cmd_issuer #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [SEL_WIDTH-1:0]    cmd_op,
  input  logic [TAG_WIDTH-1:0]    cmd_tag,
  output logic                    alu_valid_o,
  output logic [DATA_WIDTH-1:0]   alu_data1_o,
  output logic [DATA_WIDTH-1:0]   alu_data2_o,
  output logic [SEL_WIDTH-1:0]    alu_sel_o,
  input  logic                    alu_valid_i,
  input  logic [2*DATA_WIDTH-1:0] alu_data_i,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic [SEL_WIDTH-1:0]    rsp_op,
  output logic                    idle,
  output logic                    err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Extra MSB on each pointer distinguishes a full ring from an empty one.
  logic [PW-1:0] wr_ptr, fill_ptr, rd_ptr;
  logic [PW-1:0] alloc;

  logic [TAG_WIDTH-1:0]    tag_mem  [DEPTH];
  logic [SEL_WIDTH-1:0]    op_mem   [DEPTH];
  logic [2*DATA_WIDTH-1:0] data_mem [DEPTH];

  logic accept, fill_ok, pop;

  assign alloc     = wr_ptr - rd_ptr;
  // Acceptance depends only on registered pointers, so a pop in the same
  // cycle cannot open a slot for an incoming command.
  assign cmd_ready = (alloc < DEPTH_P);
  assign rsp_valid = (rd_ptr != fill_ptr);
  assign idle      = (wr_ptr == rd_ptr);

  assign accept  = cmd_valid && cmd_ready;
  assign fill_ok = alu_valid_i && (fill_ptr != wr_ptr);
  assign pop     = rsp_valid && rsp_ready;

  assign rsp_data = data_mem[rd_ptr[AW-1:0]];
  assign rsp_tag  = tag_mem[rd_ptr[AW-1:0]];
  assign rsp_op   = op_mem[rd_ptr[AW-1:0]];

  // NOTE: slot storage has no reset; every slot is written before the pointers
  // can expose it, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr[AW-1:0]] <= cmd_tag;
      op_mem[wr_ptr[AW-1:0]]  <= cmd_op;
    end
    if (fill_ok) begin
      data_mem[fill_ptr[AW-1:0]] <= alu_data_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      alu_valid_o <= 1'b0;
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      alu_sel_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      alu_valid_o <= accept;
      if (accept) begin
        wr_ptr      <= wr_ptr + 1'b1;
        alu_data1_o <= cmd_a;
        alu_data2_o <= cmd_b;
        alu_sel_o   <= cmd_op;
      end
      if (fill_ok) begin
        fill_ptr <= fill_ptr + 1'b1;
      end else if (alu_valid_i) begin
        err_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a two-stage ALU model, a queue-based
// reference of the issuer's visible behaviour, and literal spot checks.
module tb_alu_cmd_issuer;

  localparam int DW    = 8;
  localparam int SW    = 2;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic [SW-1:0] cmd_op = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          alu_valid_o;
  logic [DW-1:0] alu_data1_o, alu_data2_o;
  logic [SW-1:0] alu_sel_o;
  logic          alu_valid_i;
  logic [2*DW-1:0] alu_data_i;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [2*DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [SW-1:0] rsp_op;
  logic          idle, err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_issuer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_valid_o(alu_valid_o), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .alu_sel_o(alu_sel_o),
    .alu_valid_i(alu_valid_i), .alu_data_i(alu_data_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_op(rsp_op),
    .idle(idle), .err_o(err_o)
  );

  function automatic logic [2*DW-1:0] alu_ref(input logic [DW-1:0] a, b, input logic [SW-1:0] op);
    case (op)
      2'd0:    return {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
      2'd1:    return {{DW{1'b0}}, a} - {{DW{1'b0}}, b};
      2'd2:    return {{DW{1'b0}}, a} + 1'b1;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Team ALU: two registered stages, not tied to the issuer's reset.
  logic          s1_v = 1'b0, s2_v = 1'b0;
  logic [2*DW-1:0] s1_d = '0, s2_d = '0;
  logic          inj_v = 1'b0;
  logic [2*DW-1:0] inj_d = '0;
  always @(posedge clk) begin
    s1_v <= alu_valid_o;
    s1_d <= alu_ref(alu_data1_o, alu_data2_o, alu_sel_o);
    s2_v <= s1_v;
    s2_d <= s1_d;
  end
  assign alu_valid_i = s2_v | inj_v;
  assign alu_data_i  = inj_v ? inj_d : s2_d;

  // Reference: commands waiting for a result, then results waiting to be popped.
  typedef struct { logic [TW-1:0] tag; logic [SW-1:0] op; logic [2*DW-1:0] res; } ent_t;
  ent_t pend_q[$];
  ent_t rdy_q[$];
  logic          exp_err = 1'b0, exp_av = 1'b0;
  logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;
  logic [SW-1:0] exp_sel = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q.delete(); rdy_q.delete();
      exp_err = 1'b0; exp_av = 1'b0; exp_d1 = '0; exp_d2 = '0; exp_sel = '0;
    end else begin
      bit do_pop, do_acc;
      do_pop = (rdy_q.size() != 0) && rsp_ready;
      do_acc = cmd_valid && ((pend_q.size() + rdy_q.size()) < DEPTH);
      if (do_pop) void'(rdy_q.pop_front());
      if (alu_valid_i) begin
        if (pend_q.size() != 0) rdy_q.push_back(pend_q.pop_front());
        else exp_err = 1'b1;
      end
      exp_av = do_acc;
      if (do_acc) begin
        ent_t e;
        e.tag = cmd_tag; e.op = cmd_op; e.res = alu_ref(cmd_a, cmd_b, cmd_op);
        pend_q.push_back(e);
        exp_d1 = cmd_a; exp_d2 = cmd_b; exp_sel = cmd_op;
      end
    end
  end

  typedef struct { logic [2*DW-1:0] data; logic [TW-1:0] tag; logic [SW-1:0] op; int at; } got_t;
  got_t got_q[$];

  always @(negedge clk) begin
    int alloc;
    alloc = pend_q.size() + rdy_q.size();
    check("cmd_ready", 32'(cmd_ready), 32'(alloc < DEPTH));
    check("idle", 32'(idle), 32'(alloc == 0));
    check("err_o", 32'(err_o), 32'(exp_err));
    check("alu_valid_o", 32'(alu_valid_o), 32'(exp_av));
    check("alu_data1_o", 32'(alu_data1_o), 32'(exp_d1));
    check("alu_data2_o", 32'(alu_data2_o), 32'(exp_d2));
    check("alu_sel_o", 32'(alu_sel_o), 32'(exp_sel));
    check("rsp_valid", 32'(rsp_valid), 32'(rdy_q.size() != 0));
    if (rdy_q.size() != 0) begin
      check("rsp_data", 32'(rsp_data), 32'(rdy_q[0].res));
      check("rsp_tag", 32'(rsp_tag), 32'(rdy_q[0].tag));
      check("rsp_op", 32'(rsp_op), 32'(rdy_q[0].op));
    end
    if (alu_valid_o) vcount++;
    if (rsp_valid && rsp_ready) begin
      got_t g;
      g.data = rsp_data; g.tag = rsp_tag; g.op = rsp_op; g.at = cyc;
      got_q.push_back(g);
    end
  end

  // Called just after a rising edge; leaves cmd_valid high for back-to-back use.
  task automatic send(input logic [DW-1:0] a, b, input logic [SW-1:0] op, input logic [TW-1:0] tag);
    logic r;
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); r = cmd_ready;
      @(posedge clk); #1;
      ok = r;
    end
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && got_q.size() < n; i++) @(negedge clk);
    check("rsp_count", 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Single add: issue pulse, three-cycle response latency, back to idle.
    got_q.delete();
    send(8'h12, 8'h34, 2'd0, 4'd5);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("add_issue_valid", 32'(alu_valid_o), 32'd1);
    check("add_issue_a", 32'(alu_data1_o), 32'h12);
    check("add_issue_b", 32'(alu_data2_o), 32'h34);
    lat = 0;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(negedge clk); lat++; end
    check("add_latency", 32'(lat), 32'd3);
    check("add_data", 32'(rsp_data), 32'h0046);
    check("add_tag", 32'(rsp_tag), 32'd5);
    @(negedge clk);
    check("add_idle_after", 32'(idle), 32'd1);
    @(posedge clk); #1;

    // Sub then none, returned in order.
    got_q.delete();
    send(8'h05, 8'h07, 2'd1, 4'd1);
    send(8'h05, 8'h07, 2'd3, 4'd2);
    cmd_valid = 1'b0;
    wait_rsp(2);
    if (got_q.size() >= 2) begin
      check("sub_data", 32'(got_q[0].data), 32'hFFFE);
      check("sub_tag", 32'(got_q[0].tag), 32'd1);
      check("none_data", 32'(got_q[1].data), 32'h0000);
      check("none_tag", 32'(got_q[1].tag), 32'd2);
    end
    @(posedge clk); #1;

    // Backpressure: four fill the ring, the fifth waits for a pop.
    got_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 1), 8'h10, 2'd0, 4'(i));
    cmd_a = 8'h05; cmd_b = 8'h10; cmd_op = 2'd2; cmd_tag = 4'd4;
    repeat (6) begin
      @(negedge clk);
      check("bp_ready_low", 32'(cmd_ready), 32'd0);
      check("bp_head_tag", 32'(rsp_tag), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(8'h05, 8'h10, 2'd2, 4'd4);
    cmd_valid = 1'b0;
    wait_rsp(5);
    if (got_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("bp_order", 32'(got_q[i].tag), 32'(i));
      for (int i = 0; i < 3; i++) check("bp_back_to_back", 32'(got_q[i+1].at - got_q[i].at), 32'd1);
      check("bp_inc_data", 32'(got_q[4].data), 32'h0006);
    end
    @(posedge clk); #1;

    // Stream of 16: an entry lives five cycles with a two-stage ALU, so the
    // reference decides each cycle whether the four-deep ring has room.
    got_q.delete();
    vcount = 0;
    for (int i = 0; i < 16; i++) send(8'(i * 17 + 3), 8'(250 - i * 5), 2'(i % 4), 4'(i));
    cmd_valid = 1'b0;
    wait_rsp(16);
    check("stream_pulses", 32'(vcount), 32'd16);
    if (got_q.size() >= 16)
      for (int i = 0; i < 16; i++) check("stream_order", 32'(got_q[i].tag), 32'(i));
    @(posedge clk); #1;

    // Spurious result while idle.
    repeat (2) @(posedge clk); #1;
    inj_v = 1'b1; inj_d = 16'h1234;
    @(posedge clk); #1;
    inj_v = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("spur_err", 32'(err_o), 32'd1);
      check("spur_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // Reset with three commands in flight; late results flag an error.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_err_clear", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    send(8'h01, 8'h02, 2'd0, 4'd7);
    send(8'h03, 8'h04, 2'd0, 4'd8);
    send(8'h05, 8'h06, 2'd1, 4'd9);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_alu_valid", 32'(alu_valid_o), 32'd0);
    check("midrst_alu_a", 32'(alu_data1_o), 32'd0);
    check("midrst_alu_b", 32'(alu_data2_o), 32'd0);
    check("midrst_sel", 32'(alu_sel_o), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("late_err", 32'(err_o), 32'd1);
    check("late_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_idle", 32'(idle), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
